// File: rtl/log_reader_if.sv
// Valid/ready stream that carries log words from log_reader to the host-side link.
interface log_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/log_reader.sv
// Dumps a window of words from the full log memory, one read in flight at a time,
// and presents each word on a valid/ready stream.
module log_reader #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int LOG_DATA_WIDTH  = 32,
    parameter int MEM_LATENCY     = 1
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_first_addr,
    input  logic [BRAM_ADDR_WIDTH:0]   i_num_words,
    input  logic                       i_mem_full,
    input  logic [LOG_DATA_WIDTH-1:0]  i_data_log_from_mem,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
    log_reader_if.master               log_stream,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam int CNT_W  = BRAM_ADDR_WIDTH + 1;
    localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [CNT_W-1:0]           CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]           CNT_MAX   = {1'b1, {BRAM_ADDR_WIDTH{1'b0}}};
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ZERO = {BRAM_ADDR_WIDTH{1'b0}};
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE  = BRAM_ADDR_WIDTH'(1);
    localparam logic [WAIT_W-1:0]          WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]          WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]          WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
    localparam logic [LOG_DATA_WIDTH-1:0]  DATA_ZERO = {LOG_DATA_WIDTH{1'b0}};

    logic [2:0]                 state_r;
    logic [2:0]                 next_state_s;
    logic [WAIT_W-1:0]          wait_cnt_r;
    logic [BRAM_ADDR_WIDTH-1:0] addr_r;
    logic [BRAM_ADDR_WIDTH-1:0] addr_inc_s;
    logic [CNT_W-1:0]           remaining_r;
    logic [CNT_W-1:0]           num_sat_s;
    logic                       load_s;
    logic                       error_s;
    logic                       abort_s;
    logic                       transfer_s;
    logic                       advance_s;
    logic                       capture_s;
    logic                       read_next_s;

    assign abort_s     = i_abort & (state_r != ST_IDLE);
    assign transfer_s  = log_stream.valid & log_stream.ready;
    assign addr_inc_s  = addr_r + ADDR_ONE;
    assign num_sat_s   = (i_num_words > CNT_MAX) ? CNT_MAX : i_num_words;
    assign advance_s   = (state_r == ST_OUT) & (next_state_s == ST_ADDR);
    assign capture_s   = (state_r == ST_WAIT) & (next_state_s == ST_OUT);
    // A zero-length dump goes IDLE->DONE without ever requesting the memory.
    assign read_next_s = (next_state_s == ST_REQ) | (next_state_s == ST_ADDR) |
                         (next_state_s == ST_WAIT) | (next_state_s == ST_OUT) |
                         ((next_state_s == ST_DONE) & (state_r != ST_IDLE));

    // Next-state decode; abort outranks loss of full, transfer and completion.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        error_s      = 1'b0;
        if (abort_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        if (!i_mem_full) begin
                            error_s = 1'b1;
                        end else if (i_num_words == CNT_ZERO) begin
                            next_state_s = ST_DONE;
                        end else begin
                            next_state_s = ST_REQ;
                            load_s       = 1'b1;
                        end
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    next_state_s = ST_ADDR;
                end
                ST_ADDR: begin
                    if (!i_mem_full) begin
                        next_state_s = ST_IDLE;
                        error_s      = 1'b1;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!i_mem_full) begin
                        next_state_s = ST_IDLE;
                        error_s      = 1'b1;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        next_state_s = ST_OUT;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (!i_mem_full) begin
                        next_state_s = ST_IDLE;
                        error_s      = 1'b1;
                    end else if (transfer_s) begin
                        if (remaining_r == CNT_ONE) begin
                            next_state_s = ST_DONE;
                        end else begin
                            next_state_s = ST_ADDR;
                        end
                    end else begin
                        next_state_s = ST_OUT;
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_IDLE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register, wait counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= WAIT_ZERO;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_read_log <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= ((state_r == ST_WAIT) && (next_state_s == ST_WAIT)) ?
                          (wait_cnt_r + WAIT_ONE) : WAIT_ZERO;
            o_busy     <= (next_state_s != ST_IDLE);
            o_done     <= (next_state_s == ST_DONE);
            o_error    <= error_s;
            o_read_log <= read_next_s;
        end
    end

    // Word address, remaining count and the address presented to the memory.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            addr_r            <= ADDR_ZERO;
            remaining_r       <= CNT_ZERO;
            o_addr_log_to_mem <= ADDR_ZERO;
        end else begin
            if (load_s) begin
                addr_r      <= i_first_addr;
                remaining_r <= num_sat_s;
            end else if (advance_s) begin
                addr_r      <= addr_inc_s;
                remaining_r <= remaining_r - CNT_ONE;
            end
            if ((state_r == ST_REQ) && (next_state_s == ST_ADDR)) begin
                o_addr_log_to_mem <= addr_r;
            end else if (advance_s) begin
                o_addr_log_to_mem <= addr_inc_s;
            end
        end
    end

    // Output word register; valid holds only while the FSM sits in OUT.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            log_stream.data  <= DATA_ZERO;
            log_stream.valid <= 1'b0;
        end else if (capture_s) begin
            log_stream.data  <= i_data_log_from_mem;
            log_stream.valid <= 1'b1;
        end else if (next_state_s != ST_OUT) begin
            log_stream.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_log_reader.sv
// Scoreboard bench for log_reader: one instance with MEM_LATENCY=1 and one with 2,
// each reading a behavioural BRAM whose word[k] = 0xA5000000 | k.
module tb_log_reader;
    localparam int AW = 15;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst, start1, start2, abort, full, ready;
    logic [AW-1:0] first;
    logic [AW:0]   num;
    logic [DW-1:0] mem1, mem2, mem2_p;
    logic          rd1, rd2, busy1, busy2, done1, done2, err1, err2;
    logic [AW-1:0] addr1, addr2;

    log_reader_if #(.DATA_WIDTH(DW)) s1 ();
    log_reader_if #(.DATA_WIDTH(DW)) s2 ();
    assign s1.ready = ready;
    assign s2.ready = ready;

    log_reader #(.BRAM_ADDR_WIDTH(AW), .LOG_DATA_WIDTH(DW), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .i_rst(i_rst), .i_start(start1), .i_abort(abort),
        .i_first_addr(first), .i_num_words(num), .i_mem_full(full),
        .i_data_log_from_mem(mem1), .o_read_log(rd1), .o_addr_log_to_mem(addr1),
        .log_stream(s1), .o_busy(busy1), .o_done(done1), .o_error(err1));

    log_reader #(.BRAM_ADDR_WIDTH(AW), .LOG_DATA_WIDTH(DW), .MEM_LATENCY(2)) dut2 (
        .clk(clk), .i_rst(i_rst), .i_start(start2), .i_abort(abort),
        .i_first_addr(first), .i_num_words(num), .i_mem_full(full),
        .i_data_log_from_mem(mem2), .o_read_log(rd2), .o_addr_log_to_mem(addr2),
        .log_stream(s2), .o_busy(busy2), .o_done(done2), .o_error(err2));

    // Behavioural BRAMs: one- and two-cycle read latency.
    always @(posedge clk) begin
        mem1   <= 32'hA500_0000 | {{(DW-AW){1'b0}}, addr1};
        mem2_p <= 32'hA500_0000 | {{(DW-AW){1'b0}}, addr2};
        mem2   <= mem2_p;
    end

    int   cyc = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp1_q[$];
    exp_t exp2_q[$];
    int   xfer1_q[$];
    int   xfer2_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream monitors: every transfer is popped from the scoreboard and timestamped.
    always @(negedge clk) begin
        if (!i_rst && s1.valid && s1.ready) begin
            exp_t e;
            check_val("dut1_word_pending", 64'(exp1_q.size() != 0), 64'd1);
            if (exp1_q.size() != 0) begin
                e = exp1_q.pop_front();
                check_val("dut1_data", 64'(s1.data), 64'(e.data));
                check_val("dut1_addr", 64'(addr1), 64'(e.addr));
            end
            xfer1_q.push_back(cyc - t0);
        end
    end

    always @(negedge clk) begin
        if (!i_rst && s2.valid && s2.ready) begin
            exp_t e;
            check_val("dut2_word_pending", 64'(exp2_q.size() != 0), 64'd1);
            if (exp2_q.size() != 0) begin
                e = exp2_q.pop_front();
                check_val("dut2_data", 64'(s2.data), 64'(e.data));
                check_val("dut2_addr", 64'(addr2), 64'(e.addr));
            end
            xfer2_q.push_back(cyc - t0);
        end
    end

    // Pulses start for one cycle (start cycle = relative cycle 0) and queues expected words.
    task automatic start_dump(input int sel, input logic [AW-1:0] fa, input logic [AW:0] n);
        exp_t          e;
        logic [AW-1:0] a;
        int            cnt;
        first = fa;
        num   = n;
        t0    = cyc;
        if (sel == 1) begin
            start1 = 1'b1;
            xfer1_q.delete();
        end else begin
            start2 = 1'b1;
            xfer2_q.delete();
        end
        if (full) begin
            a   = fa;
            cnt = (int'(n) > (1 << AW)) ? (1 << AW) : int'(n);
            for (int k = 0; k < cnt; k++) begin
                e.addr = a;
                e.data = 32'hA500_0000 | {{(DW-AW){1'b0}}, a};
                if (sel == 1) exp1_q.push_back(e);
                else          exp2_q.push_back(e);
                a = a + 15'd1;
            end
        end
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic run_dump(input int sel, input int bound, output int first_v,
                            output int done_rel, output int rl_bad);
        first_v  = -1;
        done_rel = -1;
        rl_bad   = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (((sel == 1) ? s1.valid : s2.valid) && (first_v < 0)) first_v = cyc - t0;
            if (!((sel == 1) ? rd1 : rd2)) rl_bad++;
            if ((sel == 1) ? done1 : done2) begin
                done_rel = cyc - t0;
                break;
            end
        end
        check_val("done_seen", 64'(done_rel >= 0), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int            fv, dr, rb, bad, dones;
        logic [DW-1:0] d0;
        logic [AW-1:0] a0;
        i_rst = 1'b1; start1 = 1'b0; start2 = 1'b0; abort = 1'b0;
        full = 1'b1; ready = 1'b1; first = '0; num = '0;
        repeat (3) tick();
        check_val("rst_outputs1", {rd1, addr1, s1.data, s1.valid, busy1, done1, err1}, 64'd0);
        check_val("rst_outputs2", {rd2, addr2, s2.data, s2.valid, busy2, done2, err2}, 64'd0);
        i_rst = 1'b0;
        tick();

        // Basic dump: valid at 4, words every 3 cycles, done one cycle after last.
        start_dump(1, 15'h0010, 16'd4);
        check_val("basic_req_rdlog", 64'(rd1), 64'd1);
        check_val("basic_req_busy", 64'(busy1), 64'd1);
        run_dump(1, 40, fv, dr, rb);
        check_val("basic_first_valid", 64'(fv), 64'd4);
        check_val("basic_done_cycle", 64'(dr), 64'd14);
        check_val("basic_rdlog_held", 64'(rb), 64'd0);
        check_val("basic_xfer_count", 64'(xfer1_q.size()), 64'd4);
        for (int i = 0; i < xfer1_q.size(); i++)
            check_val("basic_xfer_cycle", 64'(xfer1_q[i]), 64'(4 + 3 * i));
        tick();
        check_val("basic_idle_after", {rd1, busy1, done1, s1.valid}, 64'd0);

        // Address wrap at the top of memory.
        start_dump(1, 15'h7FFE, 16'd4);
        run_dump(1, 40, fv, dr, rb);
        check_val("wrap_xfer_count", 64'(xfer1_q.size()), 64'd4);
        check_val("wrap_queue_empty", 64'(exp1_q.size()), 64'd0);
        tick();

        // Backpressure: data and address hold while ready is low.
        ready = 1'b0;
        start_dump(1, 15'h0100, 16'd3);
        for (int i = 0; i < 10 && !s1.valid; i++) tick();
        check_val("bp_valid_seen", 64'(s1.valid), 64'd1);
        d0 = s1.data; a0 = addr1; bad = 0;
        repeat (5) begin
            tick();
            if (s1.data !== d0 || addr1 !== a0 || !s1.valid) bad++;
        end
        check_val("bp_stable", 64'(bad), 64'd0);
        check_val("bp_no_xfer", 64'(xfer1_q.size()), 64'd0);
        ready = 1'b1;
        tick();
        check_val("bp_one_xfer", 64'(xfer1_q.size()), 64'd1);
        run_dump(1, 40, fv, dr, rb);
        check_val("bp_xfer_count", 64'(xfer1_q.size()), 64'd3);
        check_val("bp_queue_empty", 64'(exp1_q.size()), 64'd0);
        tick();

        // Start rejected because the memory is not full.
        full = 1'b0;
        start_dump(1, 15'h0010, 16'd4);
        check_val("rej_error_pulse", 64'(err1), 64'd1);
        check_val("rej_busy_rdlog", {busy1, rd1}, 64'd0);
        tick();
        check_val("rej_error_clear", {err1, busy1, rd1}, 64'd0);
        full = 1'b1;

        // Zero-length dump: done pulse only.
        start_dump(1, 15'h0010, 16'd0);
        check_val("zero_done_pulse", 64'(done1), 64'd1);
        check_val("zero_no_read_err", {rd1, err1}, 64'd0);
        tick();
        check_val("zero_done_clear", {done1, busy1}, 64'd0);

        // A second start mid-dump is ignored.
        start_dump(1, 15'h0020, 16'd2);
        tick();
        first = 15'h0500; num = 16'd5; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_dump(1, 40, fv, dr, rb);
        check_val("restart_xfer_count", 64'(xfer1_q.size()), 64'd2);
        check_val("restart_queue_empty", 64'(exp1_q.size()), 64'd0);
        tick();

        // Abort during WAIT of word 2 (relative cycle 6).
        start_dump(1, 15'h0030, 16'd3);
        repeat (5) tick();
        check_val("abort_pre_xfers", 64'(xfer1_q.size()), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_idle", {busy1, rd1, s1.valid, done1, err1}, 64'd0);
        dones = 0;
        repeat (4) begin
            tick();
            if (done1 || err1) dones++;
        end
        check_val("abort_no_done", 64'(dones), 64'd0);
        exp1_q.delete();

        // Loss of full while a word is waiting in OUT.
        ready = 1'b0;
        start_dump(1, 15'h0040, 16'd2);
        for (int i = 0; i < 10 && !s1.valid; i++) tick();
        full = 1'b0;
        tick();
        check_val("lof_error_pulse", 64'(err1), 64'd1);
        check_val("lof_idle", {busy1, rd1, s1.valid, done1}, 64'd0);
        tick();
        check_val("lof_error_clear", 64'(err1), 64'd0);
        full = 1'b1; ready = 1'b1;
        exp1_q.delete();

        // Reset mid-dump.
        start_dump(1, 15'h0050, 16'd3);
        repeat (4) tick();
        check_val("mid_rst_pre_addr", 64'(addr1), 64'h51);
        i_rst = 1'b1;
        tick();
        check_val("mid_rst_outputs", {rd1, addr1, s1.data, s1.valid, busy1, done1, err1}, 64'd0);
        i_rst = 1'b0;
        exp1_q.delete();
        tick();

        // MEM_LATENCY=2: valid at 5, words 4 cycles apart.
        start_dump(2, 15'h0123, 16'd2);
        check_val("lat2_req_rdlog", 64'(rd2), 64'd1);
        run_dump(2, 40, fv, dr, rb);
        check_val("lat2_first_valid", 64'(fv), 64'd5);
        check_val("lat2_done_cycle", 64'(dr), 64'd10);
        check_val("lat2_xfer_count", 64'(xfer2_q.size()), 64'd2);
        for (int i = 0; i < xfer2_q.size(); i++)
            check_val("lat2_xfer_cycle", 64'(xfer2_q[i]), 64'(5 + 4 * i));
        check_val("lat2_queue_empty", 64'(exp2_q.size()), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
